// File: rtl/led_axi_pkg.sv
// rtl/led_axi_pkg.sv - register offsets, AXI response codes and FSM states for led_axi_regs
package led_axi_pkg;

   // Word-aligned byte offsets within the 32-byte register window
   localparam logic [4:0] OFF_CNT0   = 5'h00;
   localparam logic [4:0] OFF_CNT1   = 5'h04;
   localparam logic [4:0] OFF_CNT2   = 5'h08;
   localparam logic [4:0] OFF_CNT3   = 5'h0C;
   localparam logic [4:0] OFF_CTRL   = 5'h10;
   localparam logic [4:0] OFF_STATUS = 5'h14;
   localparam logic [4:0] OFF_ID     = 5'h18;
   localparam logic [4:0] OFF_IRQ    = 5'h1C;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

endpackage

// File: rtl/axi_wstrb_merge.sv
// rtl/axi_wstrb_merge.sv - combinational byte-lane merge of old register value with write data
// Ports: old_i (current value), wdata_i (write data), wstrb_i (byte strobes), new_o (merged value)
module axi_wstrb_merge (
   input  logic [31:0] old_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wstrb_i,
   output logic [31:0] new_o
);

   always_comb begin
      new_o = old_i;
      for (int b = 0; b < 4; b++) begin
         if (wstrb_i[b]) new_o[8*b +: 8] = wdata_i[8*b +: 8];
      end
   end

endmodule

// File: rtl/led_axi_regs.sv
// rtl/led_axi_regs.sv - AXI4-Lite register bank driving LED blinker periods and enables
// Ports: clk/rst (async active-high), s_axi_* AXI4-Lite responder, cnt0..cnt3 period words,
//        sw channel enables, led_in blinker toggle readback, irq (only with LED_AXI_REGS_IRQ_EN)
// Build option: define LED_AXI_REGS_IRQ_EN to add sticky led_in edge status, CTRL[7:4] mask and irq.
module led_axi_regs
   import led_axi_pkg::*;
#(
   parameter int          ADDR_W  = 5,
   parameter logic [31:0] CNT_RST = 32'd62_500_000,
   parameter logic [31:0] ID_VAL  = 32'h4C45_4401
) (
`ifdef LED_AXI_REGS_IRQ_EN
   output logic              irq,
`endif
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [31:0]       s_axi_wdata,
   input  logic [3:0]        s_axi_wstrb,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [31:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   output logic [31:0]       cnt0,
   output logic [31:0]       cnt1,
   output logic [31:0]       cnt2,
   output logic [31:0]       cnt3,
   output logic [3:0]        sw,
   input  logic [3:0]        led_in
);

   w_state_e          w_state_q;
   r_state_e          r_state_q;
   logic              aw_have_q, w_have_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic              awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
   logic [1:0]        bresp_q, rresp_q;
   logic [31:0]       rdata_q;
   logic [31:0]       cnt_q [4];
   logic [7:0]        ctrl_q;
   logic [7:0]        ctrl_d;
`ifdef LED_AXI_REGS_IRQ_EN
   logic [3:0]        led_dly_q, irq_stat_q, irq_clr;
   logic              irq_q;
`endif

   // The commit sees address/data arriving this cycle as well as already-latched ones
   logic              aw_hs, w_hs, aw_have_d, w_have_d, commit;
   logic [ADDR_W-1:0] waddr_d;
   logic [31:0]       wdata_d;
   logic [3:0]        wstrb_d;
   logic [31:0]       wa_ext, ra_ext;
   logic [4:0]        w_off, r_off;
   logic              w_mapped, r_mapped;
   logic [3:0]        we_cnt;
   logic              we_ctrl, we_irq;
   logic [1:0]        bresp_d, rresp_d;
   logic [31:0]       rdata_d;
   logic [31:0]       rw_old [5];
   logic [31:0]       rw_new [5];
   logic              unused_bits;

   always_comb begin
      aw_hs     = s_axi_awvalid & awready_q;
      w_hs      = s_axi_wvalid & wready_q;
      aw_have_d = aw_have_q | aw_hs;
      w_have_d  = w_have_q | w_hs;
      waddr_d   = aw_hs ? s_axi_awaddr : waddr_q;
      wdata_d   = w_hs ? s_axi_wdata : wdata_q;
      wstrb_d   = w_hs ? s_axi_wstrb : wstrb_q;
      commit    = (w_state_q == W_IDLE) & aw_have_d & w_have_d;
      // Anything at or above 0x20 (only reachable when ADDR_W > 5) is unmapped
      wa_ext    = 32'(waddr_d);
      ra_ext    = 32'(s_axi_araddr);
      w_off     = {wa_ext[4:2], 2'b00};
      r_off     = {ra_ext[4:2], 2'b00};
      w_mapped  = (wa_ext[31:5] == 27'd0);
      r_mapped  = (ra_ext[31:5] == 27'd0);
   end

   always_comb begin
      we_cnt  = 4'b0000;
      we_ctrl = 1'b0;
      we_irq  = 1'b0;
      bresp_d = RESP_SLVERR;
      if (w_mapped) begin
         case (w_off)
            OFF_CNT0: begin we_cnt[0] = commit; bresp_d = RESP_OKAY; end
            OFF_CNT1: begin we_cnt[1] = commit; bresp_d = RESP_OKAY; end
            OFF_CNT2: begin we_cnt[2] = commit; bresp_d = RESP_OKAY; end
            OFF_CNT3: begin we_cnt[3] = commit; bresp_d = RESP_OKAY; end
            OFF_CTRL: begin we_ctrl   = commit; bresp_d = RESP_OKAY; end
            OFF_IRQ:  begin we_irq    = commit; bresp_d = RESP_OKAY; end
            default:  bresp_d = RESP_SLVERR;
         endcase
      end
   end

   always_comb begin
      rdata_d = 32'd0;
      rresp_d = RESP_SLVERR;
      if (r_mapped) begin
         rresp_d = RESP_OKAY;
         case (r_off)
            OFF_CNT0:   rdata_d = cnt_q[0];
            OFF_CNT1:   rdata_d = cnt_q[1];
            OFF_CNT2:   rdata_d = cnt_q[2];
            OFF_CNT3:   rdata_d = cnt_q[3];
            OFF_CTRL:   rdata_d = {24'd0, ctrl_q};
            OFF_STATUS: rdata_d = {28'd0, led_in};
            OFF_ID:     rdata_d = ID_VAL;
`ifdef LED_AXI_REGS_IRQ_EN
            OFF_IRQ:    rdata_d = {28'd0, irq_stat_q};
`endif
            default:    rdata_d = 32'd0;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) rw_old[i] = cnt_q[i];
      rw_old[4] = {24'd0, ctrl_q};
   end

   for (genvar g = 0; g < 5; g++) begin : g_merge
      axi_wstrb_merge u_merge (
         .old_i   (rw_old[g]),
         .wdata_i (wdata_d),
         .wstrb_i (wstrb_d),
         .new_o   (rw_new[g])
      );
   end

`ifdef LED_AXI_REGS_IRQ_EN
   assign ctrl_d  = rw_new[4][7:0];
   assign irq_clr = we_irq ? (wdata_d[3:0] & {4{wstrb_d[0]}}) : 4'b0000;
`else
   assign ctrl_d  = {4'b0000, rw_new[4][3:0]};
`endif

   assign unused_bits = ^{wa_ext[1:0], ra_ext[1:0], rw_new[4][31:4], we_irq};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= CNT_RST;
         ctrl_q <= 8'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (we_cnt[i]) cnt_q[i] <= rw_new[i];
         end
         if (we_ctrl) ctrl_q <= ctrl_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         aw_have_q <= 1'b0;
         w_have_q  <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               if (commit) begin
                  w_state_q <= W_RESP;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= bresp_d;
                  aw_have_q <= 1'b0;
                  w_have_q  <= 1'b0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
               end else begin
                  aw_have_q <= aw_have_d;
                  w_have_q  <= w_have_d;
                  waddr_q   <= waddr_d;
                  wdata_q   <= wdata_d;
                  wstrb_q   <= wstrb_d;
                  awready_q <= ~aw_have_d;
                  wready_q  <= ~w_have_d;
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  w_state_q <= W_IDLE;
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= 32'd0;
         rresp_q   <= 2'b00;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               if (s_axi_arvalid && arready_q) begin
                  r_state_q <= R_DATA;
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rdata_q   <= rdata_d;
                  rresp_q   <= rresp_d;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  r_state_q <= R_IDLE;
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

`ifdef LED_AXI_REGS_IRQ_EN
   // A new edge wins over a simultaneous W1C so no event is lost
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_dly_q  <= 4'd0;
         irq_stat_q <= 4'd0;
         irq_q      <= 1'b0;
      end else begin
         led_dly_q  <= led_in;
         irq_stat_q <= (irq_stat_q & ~irq_clr) | (led_in ^ led_dly_q);
         irq_q      <= |(irq_stat_q & ctrl_q[7:4]);
      end
   end
   assign irq = irq_q;
`endif

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign cnt0          = cnt_q[0];
   assign cnt1          = cnt_q[1];
   assign cnt2          = cnt_q[2];
   assign cnt3          = cnt_q[3];
   assign sw            = ctrl_q[3:0];

endmodule

// File: tb/tb_led_axi_regs.sv
// tb/tb_led_axi_regs.sv - self-checking bench for led_axi_regs (vector table plus random vs model)
module tb_led_axi_regs;

   localparam int          AW      = 6;
   localparam logic [31:0] CNT_RST = 32'd62_500_000;
   localparam logic [31:0] ID_VAL  = 32'h4C45_4401;
   localparam logic [1:0]  OK      = 2'b00;
   localparam logic [1:0]  SLV     = 2'b10;
`ifdef LED_AXI_REGS_IRQ_EN
   localparam bit          IRQ       = 1'b1;
   localparam logic [31:0] CTRL_MASK = 32'h0000_00FF;
   logic irq;
`else
   localparam bit          IRQ       = 1'b0;
   localparam logic [31:0] CTRL_MASK = 32'h0000_000F;
`endif

   logic          clk, rst;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb, sw, led_in;
   logic [1:0]    bresp, rresp;
   logic [31:0]   cnt0, cnt1, cnt2, cnt3;

   int total = 0;
   int bad   = 0;

   led_axi_regs #(.ADDR_W(AW), .CNT_RST(CNT_RST), .ID_VAL(ID_VAL)) dut (
`ifdef LED_AXI_REGS_IRQ_EN
      .irq           (irq),
`endif
      .clk           (clk),
      .rst           (rst),
      .s_axi_awaddr  (awaddr),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_bresp   (bresp),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_araddr  (araddr),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .cnt0          (cnt0),
      .cnt1          (cnt1),
      .cnt2          (cnt2),
      .cnt3          (cnt3),
      .sw            (sw),
      .led_in        (led_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      total++;
      bad++;
      $display("FAIL %s: timed out", nm);
   endtask

   // Reference model: the register map as plain arrays
   logic [31:0] m_cnt [4];
   logic [31:0] m_ctrl;
   logic [3:0]  m_stat;

   function automatic void m_reset();
      for (int i = 0; i < 4; i++) m_cnt[i] = CNT_RST;
      m_ctrl = 32'd0;
      m_stat = 4'd0;
   endfunction

   function automatic logic [1:0] m_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      int w = int'(a) / 4;
      if (w < 4) begin
         for (int b = 0; b < 4; b++) if (s[b]) m_cnt[w][8*b +: 8] = d[8*b +: 8];
         return OK;
      end
      if (w == 4) begin
         for (int b = 0; b < 4; b++) if (s[b]) m_ctrl[8*b +: 8] = d[8*b +: 8];
         return OK;
      end
      if (w == 7) begin
         if (IRQ && s[0]) m_stat = m_stat & ~d[3:0];
         return OK;
      end
      return SLV;
   endfunction

   task automatic m_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r);
      int w = int'(a) / 4;
      r = OK;
      d = 32'd0;
      if (w < 4)       d = m_cnt[w];
      else if (w == 4) d = m_ctrl & CTRL_MASK;
      else if (w == 5) d = {28'd0, led_in};
      else if (w == 6) d = ID_VAL;
      else if (w == 7) d = IRQ ? {28'd0, m_stat} : 32'd0;
      else             r = SLV;
   endtask

   function automatic logic [31:0] dut_cnt(input int i);
      case (i)
         0: return cnt0;
         1: return cnt1;
         2: return cnt2;
         default: return cnt3;
      endcase
   endfunction

   // order: 0 = AW and W together, 1 = W one cycle before AW, 2 = AW one cycle before W
   task automatic wr_hs(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s, input int order);
      bit aw_done, w_done, awh, wh;
      int t;
      aw_done = 0; w_done = 0; t = 0;
      if (order != 1) begin awaddr = a; awvalid = 1; end
      if (order != 2) begin wdata = d; wstrb = s; wvalid = 1; end
      while (!(aw_done && w_done) && t < 50) begin
         awh = awvalid && awready;
         wh  = wvalid && wready;
         @(posedge clk); #1; t++;
         if (awh) begin awvalid = 0; aw_done = 1; end
         if (wh)  begin wvalid = 0; w_done = 1; end
         if (order == 1 && w_done && !aw_done && !awvalid) begin awaddr = a; awvalid = 1; end
         if (order == 2 && aw_done && !w_done && !wvalid) begin wdata = d; wstrb = s; wvalid = 1; end
      end
      if (!(aw_done && w_done)) begin
         timeout("write handshake");
         awvalid = 0; wvalid = 0;
      end
   endtask

   task automatic wr_resp(output logic [1:0] r);
      bit got = 0;
      r = 2'bxx;
      bready = 1;
      for (int t = 0; t < 50 && !got; t++) begin
         if (bvalid) begin r = bresp; got = 1; end
         @(posedge clk); #1;
      end
      bready = 0;
      if (!got) timeout("write response");
   endtask

   task automatic rd_hs(input logic [AW-1:0] a);
      bit done = 0;
      araddr = a; arvalid = 1;
      for (int t = 0; t < 50 && !done; t++) begin
         done = arvalid && arready;
         @(posedge clk); #1;
      end
      arvalid = 0;
      if (!done) timeout("read handshake");
   endtask

   task automatic rd_data(output logic [31:0] d, output logic [1:0] r);
      bit got = 0;
      d = 32'hxxxx_xxxx; r = 2'bxx;
      rready = 1;
      for (int t = 0; t < 50 && !got; t++) begin
         if (rvalid) begin d = rdata; r = rresp; got = 1; end
         @(posedge clk); #1;
      end
      rready = 0;
      if (!got) timeout("read data");
   endtask

   task automatic rd(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r);
      rd_hs(a);
      chk("read latency rvalid", 32'(rvalid), 32'd1);
      rd_data(d, r);
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic [3:0]    strb;
      int            order;
      logic [1:0]    exp_b;
      logic [31:0]   exp_rd;
      logic [1:0]    exp_rr;
   } vec_t;

   vec_t        vecs [$];
   logic [31:0] rd_v, exp_d;
   logic [1:0]  rr_v, br_v, exp_r;
   logic [AW-1:0] ra;

   initial begin
      rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
      araddr = 0; arvalid = 0; rready = 0; led_in = 4'd0;
      m_reset();

      vecs.push_back('{6'h08, 32'h0000_0010, 4'hF,    1, OK,  32'h0000_0010, OK});
      vecs.push_back('{6'h10, 32'hFFFF_FFFF, 4'b0001, 0, OK,  CTRL_MASK,     OK});
      vecs.push_back('{6'h18, 32'h1234_5678, 4'hF,    2, SLV, ID_VAL,        OK});
      vecs.push_back('{6'h00, 32'h0000_0000, 4'hF,    0, OK,  32'h0000_0000, OK});
      vecs.push_back('{6'h04, 32'hAABB_CCDD, 4'b0101, 2, OK,  32'h03BB_ACDD, OK});
      vecs.push_back('{6'h0E, 32'h1122_3344, 4'b1000, 0, OK,  32'h11B9_ACA0, OK});
      vecs.push_back('{6'h14, 32'h0000_000F, 4'hF,    1, SLV, 32'h0000_0000, OK});
      vecs.push_back('{6'h1C, 32'hFFFF_FFFF, 4'hF,    0, OK,  32'h0000_0000, OK});
      vecs.push_back('{6'h20, 32'h0000_0001, 4'hF,    0, SLV, 32'h0000_0000, SLV});
      vecs.push_back('{6'h27, 32'h0000_0001, 4'hF,    2, SLV, 32'h0000_0000, SLV});
      vecs.push_back('{6'h10, 32'h0000_0005, 4'b0001, 1, OK,  32'h0000_0005, OK});

      repeat (3) @(posedge clk);
      #1;
      chk("reset cnt0", cnt0, CNT_RST);
      chk("reset cnt1", cnt1, CNT_RST);
      chk("reset cnt2", cnt2, CNT_RST);
      chk("reset cnt3", cnt3, 32'h03B9_ACA0);
      chk("reset sw", 32'(sw), 32'd0);
      chk("reset bvalid", 32'(bvalid), 32'd0);
      chk("reset rvalid", 32'(rvalid), 32'd0);
      chk("reset awready", 32'(awready), 32'd0);
      chk("reset arready", 32'(arready), 32'd0);
      rst = 0;
      @(posedge clk); #1;

      rd(6'h18, rd_v, rr_v);
      chk("id rdata", rd_v, 32'h4C45_4401);
      chk("id rresp", 32'(rr_v), 32'(OK));

      foreach (vecs[i]) begin
         wr_hs(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].order);
         void'(m_write(vecs[i].addr, vecs[i].data, vecs[i].strb));
         if (int'(vecs[i].addr) < 16)
            chk($sformatf("vec%0d cnt out", i), dut_cnt(int'(vecs[i].addr) / 4), vecs[i].exp_rd);
         wr_resp(br_v);
         chk($sformatf("vec%0d bresp", i), 32'(br_v), 32'(vecs[i].exp_b));
         rd(vecs[i].addr, rd_v, rr_v);
         chk($sformatf("vec%0d rdata", i), rd_v, vecs[i].exp_rd);
         chk($sformatf("vec%0d rresp", i), 32'(rr_v), 32'(vecs[i].exp_rr));
         chk($sformatf("vec%0d sw", i), 32'(sw), 32'(m_ctrl[3:0]));
      end

      // Both responses held off: everything must stay frozen, then reset drops them
      wr_hs(6'h00, 32'hDEAD_0001, 4'hF, 0);
      void'(m_write(6'h00, 32'hDEAD_0001, 4'hF));
      rd_hs(6'h00);
      for (int c = 0; c < 5; c++) begin
         chk("hold bvalid", 32'(bvalid), 32'd1);
         chk("hold bresp", 32'(bresp), 32'(OK));
         chk("hold rvalid", 32'(rvalid), 32'd1);
         chk("hold rdata", rdata, 32'hDEAD_0001);
         chk("hold awready", 32'(awready), 32'd0);
         chk("hold wready", 32'(wready), 32'd0);
         chk("hold arready", 32'(arready), 32'd0);
         @(posedge clk); #1;
      end
      rst = 1;
      @(posedge clk); #1;
      chk("midrst bvalid", 32'(bvalid), 32'd0);
      chk("midrst rvalid", 32'(rvalid), 32'd0);
      chk("midrst cnt0", cnt0, CNT_RST);
      chk("midrst sw", 32'(sw), 32'd0);
      rst = 0;
      m_reset();
      @(posedge clk); #1;

      led_in = 4'b1010;
      if (IRQ) m_stat = m_stat | 4'b1010;
      repeat (3) @(posedge clk);
      #1;
      for (int n = 0; n < 40; n++) begin
         logic [AW-1:0] a;
         logic [31:0]   d;
         logic [3:0]    s;
         a = AW'($urandom_range(0, 39));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         wr_hs(a, d, s, int'($urandom_range(0, 2)));
         exp_r = m_write(a, d, s);
         wr_resp(br_v);
         chk($sformatf("rnd%0d bresp a=%h", n, a), 32'(br_v), 32'(exp_r));
         ra = AW'($urandom_range(0, 39));
         rd(ra, rd_v, rr_v);
         m_read(ra, exp_d, exp_r);
         chk($sformatf("rnd%0d rdata a=%h", n, ra), rd_v, exp_d);
         chk($sformatf("rnd%0d rresp a=%h", n, ra), 32'(rr_v), 32'(exp_r));
         for (int i = 0; i < 4; i++) chk($sformatf("rnd%0d cnt%0d", n, i), dut_cnt(i), m_cnt[i]);
         chk($sformatf("rnd%0d sw", n), 32'(sw), 32'(m_ctrl[3:0]));
`ifdef LED_AXI_REGS_IRQ_EN
         chk($sformatf("rnd%0d irq", n), 32'(irq), 32'(|(m_stat & m_ctrl[7:4])));
`endif
      end

`ifdef LED_AXI_REGS_IRQ_EN
      wr_hs(6'h1C, 32'h0000_000F, 4'hF, 0);
      void'(m_write(6'h1C, 32'h0000_000F, 4'hF));
      wr_resp(br_v);
      wr_hs(6'h10, 32'h0000_0020, 4'b0001, 0);
      void'(m_write(6'h10, 32'h0000_0020, 4'b0001));
      wr_resp(br_v);
      led_in = 4'b1000;
      repeat (3) @(posedge clk);
      #1;
      rd(6'h1C, rd_v, rr_v);
      chk("irq stat ch1", rd_v, 32'h0000_0002);
      chk("irq asserted", 32'(irq), 32'd1);
      wr_hs(6'h1C, 32'h0000_0002, 4'hF, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("irq cleared", 32'(irq), 32'd0);
      wr_resp(br_v);
      chk("irq w1c bresp", 32'(br_v), 32'(OK));
      rd(6'h1C, rd_v, rr_v);
      chk("irq stat cleared", rd_v, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_axi_regs.md
Name: led_axi_regs

Overview:
- AXI4-Lite responder (slave) register bank that generates the per-channel period words and enable bits consumed by the LED blinker.
- Also reads the four LED toggle outputs back to the PS.
- Sits between the Zynq PS M_AXI_GP port and the LED blinker. Single clock domain shared with the blinker.

Parameters:
- ADDR_W, 5, AXI address width (byte address); register space is 0x00–0x1F.
- CNT_RST, 32'd62_500_000, reset value of every CNT register (0.5 s at 125 MHz).
- ID_VAL, 32'h4C45_4401, constant returned by the ID register.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- s_axi_awaddr  in  ADDR_W  write address
- s_axi_awvalid  in  1  write-address valid
- s_axi_awready  out  1  write-address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid  in  1  write-data valid
- s_axi_wready  out  1  write-data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_W  read address
- s_axi_arvalid  in  1  read-address valid
- s_axi_arready  out  1  read-address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- cnt0..cnt3  out  32 each  period words to the blinker
- sw  out  4  per-channel enable to the blinker
- led_in  in  4  blinker toggle outputs, same clock domain

Behaviour:
- Register map (word-aligned; addr[1:0] ignored):
  - 0x00/0x04/0x08/0x0C: CNT0–CNT3, RW
  - 0x10: CTRL, RW, bits[3:0] = sw; upper bits read 0
  - 0x14: STATUS, RO, bits[3:0] = led_in
  - 0x18: ID, RO, = ID_VAL
  - 0x1C: IRQ_STAT, see Optional Feature; reads 0 when the feature is compiled out
- Reset values (asynchronous, on rst high):
  - CNTn = CNT_RST; CTRL = 0
  - awready, wready, arready = 0; bvalid, rvalid = 0
  - bresp, rresp, rdata = 0
- Write FSM, states W_IDLE → W_RESP:
  - In W_IDLE, awready is high while no address is latched and wready is high while no data is latched. AW and W may arrive in either order or in the same cycle; each is latched on its own handshake.
  - When both are latched, the register update (honouring wstrb per byte) happens on that edge and bvalid is asserted the next cycle (W_RESP).
  - bvalid holds until bready; then return to W_IDLE. awready and wready stay low throughout W_RESP.
- Write response:
  - bresp = OKAY (00) for CNTn and CTRL.
  - bresp = SLVERR (10) for STATUS, ID and unmapped offsets; these writes are ignored.
- Read FSM, states R_IDLE → R_DATA:
  - arready is high in R_IDLE.
  - On AR handshake, rdata and rresp are registered (one-cycle latency) and rvalid is asserted.
  - rdata, rresp and rvalid hold stable until rready; arready is low in R_DATA.
  - rresp = OKAY for all mapped offsets, SLVERR for unmapped offsets (with rdata = 0).
- Read and write channels are independent. A read sampled on the same edge as a write commit to the same register returns the pre-write value.
- CNTn value 0 is stored as written (the blinker treats it as toggle-every-cycle). No clamping.
- rst asserted mid-transaction: both FSMs return to idle immediately, pending responses are dropped, all registers take reset values.
- cnt0..3 and sw are driven directly from the register flops (no extra pipeline).

Optional Feature:
- Macro: LED_AXI_REGS_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit).
  - IRQ_STAT[3:0] sets sticky on any led_in[n] edge, detected via a one-cycle delayed copy of led_in.
  - Writing 1 to a bit clears it (W1C). A set and a clear in the same cycle leave the bit set.
  - CTRL[7:4] = per-channel irq mask.
  - irq = |(IRQ_STAT[3:0] & CTRL[7:4]), registered; reset 0.
- When undefined: no irq port; IRQ_STAT reads 0 with OKAY; writes to it return OKAY and are ignored; CTRL[7:4] reads 0.

Decomposition:
- Package led_axi_pkg holds:
  - register offset localparams (OFF_CNT0..OFF_IRQ)
  - RESP_OKAY and RESP_SLVERR
  - write and read FSM state encodings
- One natural sub-module, axi_wstrb_merge: combinational byte-merge of old value, wdata and wstrb. It is reused for every RW register.

Test Plan:
- Reset → cnt0..3 = 0x03B9ACA0 (62_500_000), sw = 0, bvalid = rvalid = 0; read ID → 0x4C454401, rresp = 00.
- Write CNT2 = 0x0000_0010 with W one cycle before AW, strb = F → bresp = 00, cnt2 = 0x10 one cycle after the second handshake; read back 0x10.
- Write CTRL = 0xFFFF_FFFF with strb = 4'b0001 → sw = 4'hF; upper bits read 0 (IRQ compiled out) or 0xF0 in bits[7:4] (IRQ compiled in).
- Write to 0x18 and read 0x20-aliased unmapped offset (ADDR_W widened in bench) → bresp = 10, ID unchanged; rresp = 10, rdata = 0.
- Hold bready/rready low 5 cycles → bvalid/rvalid and rdata stable, awready/wready/arready low; assert rst mid-hold → all valids 0 next edge.
- With LED_AXI_REGS_IRQ_EN: mask ch1, toggle led_in[1] → IRQ_STAT = 0x2, irq = 1; W1C 0x2 → irq = 0 two cycles later.
